// File: rtl/datapath_sequencer.sv
// Multi-cycle sequencer that fetches, decodes and drives the datapath control word.
// 2 cycles per instruction (LD 3); controls combinational from state/IR; start only sampled in IDLE/HALT.
module datapath_sequencer #(
    parameter int         size    = 8,
    parameter logic [3:0] FS_ADD  = 4'b0010,
    parameter logic [3:0] FS_MOVB = 4'b1100
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [size-1:0] instr_addr,
    input  logic [15:0]     instr_data,
    input  logic            V,
    input  logic            C,
    input  logic            N,
    input  logic            Z,
    input  logic [size-1:0] jump_address,
    output logic            MB,
    output logic            RW,
    output logic            MD,
    output logic            MW,
    output logic [1:0]      DA,
    output logic [1:0]      AA,
    output logic [1:0]      BA,
    output logic [3:0]      FS,
    output logic [size-1:0] constant,
    output logic            busy,
    output logic            halted
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

    localparam logic [3:0] OP_ALU  = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_LDI  = 4'h3;
    localparam logic [3:0] OP_LD   = 4'h4;
    localparam logic [3:0] OP_ST   = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h6;
    localparam logic [3:0] OP_JR   = 4'h7;
    localparam logic [3:0] OP_BZ   = 4'h8;
    localparam logic [3:0] OP_BN   = 4'h9;
    localparam logic [3:0] OP_BC   = 4'hA;
    localparam logic [3:0] OP_BV   = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t          state, state_nxt;
    logic [size-1:0] pc, pc_nxt, pc_inc, imm_ext;
    logic [15:0]     ir, ir_nxt;
    logic [3:0]      flags, flags_nxt;
    logic [3:0]      op;

    assign op         = ir[15:12];
    assign pc_inc     = pc + size'(1);
    assign imm_ext    = size'(ir[7:0]);
    assign instr_addr = pc;
    assign busy       = (state == S_FETCH) || (state == S_EXEC) || (state == S_MEM);
    assign halted     = (state == S_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pc    <= '0;
            ir    <= '0;
            flags <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            ir    <= ir_nxt;
            flags <= flags_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_nxt    = ir;
        flags_nxt = flags;
        MB        = 1'b0;
        RW        = 1'b0;
        MD        = 1'b0;
        MW        = 1'b0;
        DA        = 2'b00;
        AA        = 2'b00;
        BA        = 2'b00;
        FS        = 4'b0000;
        constant  = '0;

        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                ir_nxt    = instr_data;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                DA        = ir[11:10];
                AA        = ir[9:8];
                BA        = ir[7:6];
                constant  = imm_ext;
                state_nxt = S_FETCH;
                pc_nxt    = pc_inc;
                case (op)
                    OP_ALU: begin
                        FS        = ir[3:0];
                        RW        = 1'b1;
                        flags_nxt = {V, C, N, Z};
                    end
                    OP_ADDI: begin
                        FS        = FS_ADD;
                        MB        = 1'b1;
                        RW        = 1'b1;
                        flags_nxt = {V, C, N, Z};
                    end
                    OP_LDI: begin
                        FS = FS_MOVB;
                        MB = 1'b1;
                        RW = 1'b1;
                    end
                    OP_LD: begin
                        MD        = 1'b1;
                        pc_nxt    = pc;
                        state_nxt = S_MEM;
                    end
                    OP_ST:  MW     = 1'b1;
                    OP_JMP: pc_nxt = imm_ext;
                    OP_JR:  pc_nxt = jump_address;
                    // op[1:0] picks Z/N/C/V out of the {V,C,N,Z} flag register
                    OP_BZ, OP_BN, OP_BC, OP_BV: begin
                        if (flags[op[1:0]]) pc_nxt = imm_ext;
                    end
                    OP_HALT: begin
                        pc_nxt    = pc;
                        state_nxt = S_HALT;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                DA        = ir[11:10];
                AA        = ir[9:8];
                MD        = 1'b1;
                RW        = 1'b1;
                pc_nxt    = pc_inc;
                state_nxt = S_FETCH;
            end
            S_HALT: begin
                if (start) begin
                    pc_nxt    = '0;
                    flags_nxt = '0;
                    state_nxt = S_FETCH;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: directed programs plus random ROMs checked by an instruction-level model.
module tb_datapath_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  instr_addr;
    logic [15:0] instr_data;
    logic        V, C, N, Z;
    logic [7:0]  jump_address;
    logic        MB, RW, MD, MW;
    logic [1:0]  DA, AA, BA;
    logic [3:0]  FS;
    logic [7:0]  constant;
    logic        busy, halted;

    logic [15:0] rom [256];
    logic [21:0] ctl;

    int n_chk  = 0;
    int n_pass = 0;
    int mw_cnt = 0;
    int busy_cnt = 0;

    // architectural model state
    logic [7:0] m_pc;
    logic       m_v, m_c, m_n, m_z;

    bit         rand_flags;
    logic [3:0] fixed_flags;
    logic [7:0] fixed_ja;

    assign instr_data = rom[instr_addr];
    assign ctl = {MB, RW, MD, MW, DA, AA, BA, FS, constant};

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (MW)   mw_cnt++;
        if (busy) busy_cnt++;
    end

    datapath_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .instr_addr(instr_addr), .instr_data(instr_data),
        .V(V), .C(C), .N(N), .Z(Z), .jump_address(jump_address),
        .MB(MB), .RW(RW), .MD(MD), .MW(MW),
        .DA(DA), .AA(AA), .BA(BA), .FS(FS), .constant(constant),
        .busy(busy), .halted(halted)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Control word an instruction must present during its EXEC cycle.
    function automatic logic [21:0] exp_exec(input logic [15:0] ir);
        logic       mb, rw, md, mw;
        logic [3:0] fs;
        mb = 1'b0; rw = 1'b0; md = 1'b0; mw = 1'b0; fs = 4'h0;
        case (ir[15:12])
            4'h1: begin fs = ir[3:0]; rw = 1'b1; end
            4'h2: begin fs = 4'b0010; mb = 1'b1; rw = 1'b1; end
            4'h3: begin fs = 4'b1100; mb = 1'b1; rw = 1'b1; end
            4'h4: md = 1'b1;
            4'h5: mw = 1'b1;
            default: ;
        endcase
        return {mb, rw, md, mw, ir[11:10], ir[9:8], ir[7:6], fs, ir[7:0]};
    endfunction

    task automatic drive_inputs(input bit may_start);
        if (rand_flags) begin
            {V, C, N, Z} = 4'($urandom);
            jump_address = 8'($urandom);
        end else begin
            {V, C, N, Z} = fixed_flags;
            jump_address = fixed_ja;
        end
        start = may_start ? 1'($urandom) : 1'b0;
    endtask

    // Entered at the falling edge inside FETCH; returns at the next FETCH (or in HALT).
    task automatic step_instr(output bit h);
        logic [15:0] ir;
        logic [3:0]  op;
        logic [3:0]  f;
        logic [7:0]  ja;
        bit          take;
        h = 1'b0;
        chk("fetch_status", 32'({busy, halted}), 32'h2);
        chk("fetch_addr", 32'(instr_addr), 32'(m_pc));
        chk("fetch_ctl", 32'(ctl), 32'h0);
        ir = rom[m_pc];
        op = ir[15:12];
        drive_inputs(1'b1);
        @(negedge clk);
        chk("exec_status", 32'({busy, halted}), 32'h2);
        chk("exec_addr", 32'(instr_addr), 32'(m_pc));
        chk("exec_ctl", 32'(ctl), 32'(exp_exec(ir)));
        drive_inputs(1'b1);
        f  = {V, C, N, Z};
        ja = jump_address;
        case (op)
            4'h1, 4'h2: begin
                {m_v, m_c, m_n, m_z} = f;
                m_pc = 8'(m_pc + 1);
            end
            4'h4: begin
                @(negedge clk);
                chk("mem_status", 32'({busy, halted}), 32'h2);
                chk("mem_addr", 32'(instr_addr), 32'(m_pc));
                chk("mem_ctl", 32'(ctl), 32'({4'b0110, ir[11:8], 14'h0}));
                drive_inputs(1'b1);
                m_pc = 8'(m_pc + 1);
            end
            4'h6: m_pc = ir[7:0];
            4'h7: m_pc = ja;
            4'h8, 4'h9, 4'hA, 4'hB: begin
                if (op == 4'h8)      take = m_z;
                else if (op == 4'h9) take = m_n;
                else if (op == 4'hA) take = m_c;
                else                 take = m_v;
                m_pc = take ? ir[7:0] : 8'(m_pc + 1);
            end
            4'hF: h = 1'b1;
            default: m_pc = 8'(m_pc + 1);
        endcase
        @(negedge clk);
        if (h) begin
            start = 1'b0;
            chk("halt_status", 32'({busy, halted}), 32'h1);
            chk("halt_addr", 32'(instr_addr), 32'(m_pc));
            chk("halt_ctl", 32'(ctl), 32'h0);
        end
    endtask

    task automatic run_prog(input int budget, output bit h);
        h = 1'b0;
        start = 1'b1;
        m_pc = 8'h00;
        {m_v, m_c, m_n, m_z} = 4'h0;
        @(negedge clk);
        for (int i = 0; i < budget && !h; i++) step_instr(h);
    endtask

    // Asserts reset with start high; start must lose.
    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b1;
        #1;
        chk("rst_ctl", 32'(ctl), 32'h0);
        chk("rst_status", 32'({busy, halted}), 32'h0);
        chk("rst_addr", 32'(instr_addr), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        m_pc = 8'h00;
        {m_v, m_c, m_n, m_z} = 4'h0;
        @(negedge clk);
        chk("idle_status", 32'({busy, halted}), 32'h0);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        bit h;
        int mw0, b0;
        rst_n = 1'b0; start = 1'b0;
        {V, C, N, Z} = 4'h0; jump_address = 8'h00;
        rand_flags = 1'b1; fixed_flags = 4'h0; fixed_ja = 8'h00;
        clear_rom();
        @(negedge clk);

        // LDI then HALT
        rom[0] = 16'h3040; rom[1] = 16'hF000;
        do_reset();
        run_prog(10, h);
        chk("ldi_halted", 32'(h), 32'h1);
        chk("ldi_pc", 32'(instr_addr), 32'h01);

        // ADDI sets Z/C, BZ taken
        clear_rom();
        rom[0] = 16'h24C0; rom[1] = 16'h8010; rom[2] = 16'hF000; rom[8'h10] = 16'hF000;
        rand_flags = 1'b0; fixed_flags = 4'b0101;
        run_prog(10, h);
        chk("bz_taken_addr", 32'(instr_addr), 32'h10);

        // same program, Z clear: falls through
        fixed_flags = 4'b0000;
        run_prog(10, h);
        chk("bz_fall_addr", 32'(instr_addr), 32'h02);

        // ST then LD
        clear_rom();
        rom[0] = 16'h5140; rom[1] = 16'h4900; rom[2] = 16'hF000;
        rand_flags = 1'b1;
        mw0 = mw_cnt; b0 = busy_cnt;
        run_prog(10, h);
        chk("st_mw_cycles", 32'(mw_cnt - mw0), 32'd1);
        chk("st_ld_busy_cycles", 32'(busy_cnt - b0), 32'd7);

        // PC wrap through 0xFF, then BZ on latched Z, then JR
        clear_rom();
        rom[0] = 16'h8010; rom[1] = 16'h2000; rom[2] = 16'h60FF; rom[8'hFF] = 16'h0000;
        rom[8'h10] = 16'h7000; rom[8'h33] = 16'hF000;
        rand_flags = 1'b0; fixed_flags = 4'b0001; fixed_ja = 8'h33;
        run_prog(20, h);
        chk("wrap_jr_halted", 32'(h), 32'h1);
        chk("wrap_jr_addr", 32'(instr_addr), 32'h33);

        // reset during the MEM cycle of LD
        clear_rom();
        rom[0] = 16'h0000; rom[1] = 16'h4900; rom[2] = 16'hF000;
        rand_flags = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_mem_ctl", 32'({MD, RW, MW}), 32'b110);
        chk("pre_rst_addr", 32'(instr_addr), 32'h01);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_ctl", 32'(ctl), 32'h0);
        chk("abort_status", 32'({busy, halted}), 32'h0);
        chk("abort_addr", 32'(instr_addr), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("abort_idle", 32'({busy, halted}), 32'h0);
        end
        run_prog(10, h);
        chk("resume_halted", 32'(h), 32'h1);
        chk("resume_addr", 32'(instr_addr), 32'h02);

        // random programs, random flags/jump targets/start noise
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
            do_reset();
            run_prog(50, h);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
